// File: rtl/mbist_march_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mbist_march_pkg : shared types and constants for the March C- BIST   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mbist_march_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic is_rd;
        logic inv;      // 0 = background, 1 = inverted background
    } march_op_t;

    typedef struct packed {
        logic      down;
        logic      two_ops;
        march_op_t op0;
        march_op_t op1;
    } march_elem_t;

    localparam int c_num_elem = 6;

    // Fields per element: {down, two_ops, rd0, inv0, rd1, inv1}; index 0 = E0
    localparam march_elem_t [c_num_elem-1:0] c_march_tbl = {
        6'b00_10_00,    // E5 up   (r0)
        6'b11_11_00,    // E4 down (r1,w0)
        6'b11_10_01,    // E3 down (r0,w1)
        6'b01_11_00,    // E2 up   (r1,w0)
        6'b01_10_01,    // E1 up   (r0,w1)
        6'b00_00_00     // E0 up   (w0)
    };

    localparam logic [255:0] c_bg0_pat = '0;
    localparam logic [255:0] c_bg1_pat = {128{2'b01}};

endpackage
`default_nettype wire

// File: rtl/mbist_repair_tbl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mbist_repair_tbl : failing-row capture table and functional remap    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mbist_repair_tbl #(
    parameter int unsigned ADDR_WD           = 9,
    parameter int unsigned REPAIR_ADDR_START = 'h1FC,
    parameter int unsigned REPAIR_CNT        = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_log_vld,
    input  logic [ADDR_WD-1:0] i_log_addr,
    input  logic [ADDR_WD-1:0] i_func_addr,
    output logic [ADDR_WD-1:0] o_func_addr,
    output logic [3:0]         o_repair_cnt,
    output logic               o_overflow
);

    localparam logic [ADDR_WD-1:0] c_repair_start = REPAIR_ADDR_START[ADDR_WD-1:0];

    logic [REPAIR_CNT-1:0] r_vld;
    logic [ADDR_WD-1:0]    r_addr [REPAIR_CNT];
    logic [3:0]            r_cnt;
    logic                  w_hit;
    logic                  w_full;
    logic                  w_alloc;

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < int'(REPAIR_CNT); i++) begin
            if (r_vld[i] && (r_addr[i] == i_log_addr)) w_hit = 1'b1;
        end
    end

    assign w_full     = (r_cnt == 4'(REPAIR_CNT));
    assign w_alloc    = i_log_vld && !w_hit && !w_full;
    assign o_overflow = i_log_vld && !w_hit && w_full;

    always_ff @(posedge clk) begin
        if (rst || i_clear)  r_cnt <= 4'd0;
        else if (w_alloc)    r_cnt <= r_cnt + 4'd1;
    end

    for (genvar i = 0; i < int'(REPAIR_CNT); i++) begin : g_entry
        always_ff @(posedge clk) begin
            if (rst || i_clear) begin
                r_vld[i]  <= 1'b0;
                r_addr[i] <= '0;
            end else if (w_alloc && (r_cnt == 4'(i))) begin
                r_vld[i]  <= 1'b1;
                r_addr[i] <= i_log_addr;
            end
        end
    end

    // Scan from the top down so the lowest matching index has the final say
    always_comb begin
        o_func_addr = i_func_addr;
        for (int i = int'(REPAIR_CNT) - 1; i >= 0; i--) begin
            if (r_vld[i] && (r_addr[i] == i_func_addr))
                o_func_addr = c_repair_start + ADDR_WD'(i);
        end
    end

    assign o_repair_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/mbist_march_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mbist_march_ctrl : March C- memory BIST with two data backgrounds;   |
// | spare-row repair and remap present when MBIST_REPAIR_EN is defined.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mbist_march_ctrl
    import mbist_march_pkg::*;
#(
    parameter int unsigned BIST_ADDR_WD           = 9,
    parameter int unsigned BIST_DATA_WD           = 32,
    parameter int unsigned BIST_ADDR_START        = 0,
    parameter int unsigned BIST_ADDR_END          = 'h1F8,
    parameter int unsigned BIST_REPAIR_ADDR_START = 'h1FC,
    parameter int unsigned BIST_REPAIR_CNT        = 4
) (
    input  logic                    bist_clk,
    input  logic                    bist_rst,
    input  logic                    bist_en,
    input  logic                    bist_run,
    output logic                    bist_done,
    output logic                    bist_error,
    output logic                    bist_correct,
    output logic [3:0]              bist_error_cnt,
    output logic [3:0]              bist_repair_cnt,
    input  logic                    func_cen,
    input  logic                    func_web,
    input  logic [BIST_ADDR_WD-1:0] func_addr,
    input  logic [BIST_DATA_WD-1:0] func_din,
    output logic [BIST_DATA_WD-1:0] func_dout,
    output logic                    mem_cen,
    output logic                    mem_web,
    output logic [BIST_ADDR_WD-1:0] mem_addr,
    output logic [BIST_DATA_WD-1:0] mem_din,
    input  logic [BIST_DATA_WD-1:0] mem_dout
);

    localparam logic [BIST_ADDR_WD-1:0] c_addr_start = BIST_ADDR_START[BIST_ADDR_WD-1:0];
    localparam logic [BIST_ADDR_WD-1:0] c_addr_end   = BIST_ADDR_END[BIST_ADDR_WD-1:0];
    localparam logic [2:0]              c_elem_last  = 3'(c_num_elem - 1);

    if ((BIST_REPAIR_CNT < 1) || (BIST_REPAIR_CNT > 8) ||
        (BIST_REPAIR_ADDR_START <= BIST_ADDR_END) || ((BIST_DATA_WD % 2) != 0)) begin : g_cfg_err
        $error("mbist_march_ctrl: illegal parameter combination");
    end

    state_t                  r_state, w_state_nxt;
    logic [2:0]              r_elem;
    logic                    r_op;
    logic [BIST_ADDR_WD-1:0] r_addr;
    logic                    r_bg;
    logic                    r_rd_vld;
    logic [BIST_DATA_WD-1:0] r_exp;
    logic                    r_error;
    logic [3:0]              r_err_cnt;

    march_elem_t             w_elem;
    march_op_t               w_op;
    logic [2:0]              w_next_elem;
    logic                    w_elem_addr_last;
    logic                    w_op_last;
    logic                    w_last_op;
    logic                    w_start;
    logic [BIST_DATA_WD-1:0] w_bg_data;
    logic [BIST_DATA_WD-1:0] w_op_data;
    logic                    w_mismatch;
    logic                    w_fatal_miss;
    logic [3:0]              w_repair_cnt;
    logic [BIST_ADDR_WD-1:0] w_func_addr_map;

    assign w_elem           = c_march_tbl[r_elem];
    assign w_op             = r_op ? w_elem.op1 : w_elem.op0;
    assign w_next_elem      = (r_elem == c_elem_last) ? 3'd0 : r_elem + 3'd1;
    assign w_elem_addr_last = w_elem.down ? (r_addr == c_addr_start) : (r_addr == c_addr_end);
    assign w_op_last        = !w_elem.two_ops || r_op;
    assign w_last_op        = r_bg && (r_elem == c_elem_last) && w_elem_addr_last && w_op_last;
    assign w_start          = (r_state == ST_IDLE) && bist_run && bist_en;
    assign w_bg_data        = r_bg ? c_bg1_pat[BIST_DATA_WD-1:0] : c_bg0_pat[BIST_DATA_WD-1:0];
    assign w_op_data        = w_op.inv ? ~w_bg_data : w_bg_data;
    assign w_mismatch       = r_rd_vld && (mem_dout != r_exp);

    always_ff @(posedge bist_clk) begin
        if (bist_rst) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bist_run && bist_en) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_last_op)           w_state_nxt = ST_FLUSH;
            ST_FLUSH:                          w_state_nxt = ST_DONE;
            ST_DONE:                           w_state_nxt = ST_DONE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
        if (!bist_run) w_state_nxt = ST_IDLE;
    end

    always_comb begin
        bist_done = (r_state == ST_DONE);
        if (bist_en) begin
            mem_cen  = (r_state != ST_RUN);
            mem_web  = !((r_state == ST_RUN) && !w_op.is_rd);
            mem_addr = r_addr;
            mem_din  = w_op_data;
        end else begin
            mem_cen  = func_cen;
            mem_web  = func_web;
            mem_addr = w_func_addr_map;
            mem_din  = func_din;
        end
    end

    // Sequencer: one op per cycle, elements and backgrounds chained back to back
    always_ff @(posedge bist_clk) begin
        if (bist_rst || w_start) begin
            r_elem <= 3'd0;
            r_op   <= 1'b0;
            r_addr <= c_addr_start;
            r_bg   <= 1'b0;
        end else if (r_state == ST_RUN) begin
            if (w_elem.two_ops && !r_op) begin
                r_op <= 1'b1;
            end else begin
                r_op <= 1'b0;
                if (w_elem_addr_last) begin
                    r_elem <= w_next_elem;
                    r_addr <= c_march_tbl[w_next_elem].down ? c_addr_end : c_addr_start;
                    if (r_elem == c_elem_last) r_bg <= ~r_bg;
                end else begin
                    r_addr <= w_elem.down ? r_addr - 1'b1 : r_addr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge bist_clk) begin
        if (bist_rst) begin
            r_rd_vld <= 1'b0;
            r_exp    <= '0;
        end else begin
            r_rd_vld <= (r_state == ST_RUN) && w_op.is_rd;
            r_exp    <= w_op_data;
        end
    end

    always_ff @(posedge bist_clk) begin
        if (bist_rst || w_start) begin
            r_err_cnt <= 4'd0;
            r_error   <= 1'b0;
        end else begin
            if (w_mismatch && (r_err_cnt != 4'hF)) r_err_cnt <= r_err_cnt + 4'd1;
            if (w_fatal_miss)                      r_error   <= 1'b1;
        end
    end

`ifdef MBIST_REPAIR_EN
    logic [BIST_ADDR_WD-1:0] r_rd_addr;

    always_ff @(posedge bist_clk) begin
        if (bist_rst) r_rd_addr <= '0;
        else          r_rd_addr <= r_addr;
    end

    mbist_repair_tbl #(
        .ADDR_WD           (BIST_ADDR_WD),
        .REPAIR_ADDR_START (BIST_REPAIR_ADDR_START),
        .REPAIR_CNT        (BIST_REPAIR_CNT)
    ) u_repair_tbl (
        .clk          (bist_clk),
        .rst          (bist_rst),
        .i_clear      (w_start),
        .i_log_vld    (w_mismatch),
        .i_log_addr   (r_rd_addr),
        .i_func_addr  (func_addr),
        .o_func_addr  (w_func_addr_map),
        .o_repair_cnt (w_repair_cnt),
        .o_overflow   (w_fatal_miss)
    );
`else
    // No spares: any mismatch is unrepairable
    assign w_fatal_miss    = w_mismatch;
    assign w_repair_cnt    = 4'd0;
    assign w_func_addr_map = func_addr;
`endif

    assign bist_error      = r_error;
    assign bist_error_cnt  = r_err_cnt;
    assign bist_repair_cnt = w_repair_cnt;
    assign bist_correct    = bist_done && !r_error && (w_repair_cnt != 4'd0);
    assign func_dout       = mem_dout;

endmodule
`default_nettype wire

// File: doc/mbist_march_ctrl.md
MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
REQ-001 Parameters, each given as name, default and meaning:
- BIST_ADDR_WD, 9: address width.
- BIST_DATA_WD, 32: data width (even).
- BIST_ADDR_START, 0: first tested address.
- BIST_ADDR_END, 'h1F8: last tested address.
- BIST_REPAIR_ADDR_START, 'h1FC: first spare row.
- BIST_REPAIR_CNT, 4: spare-row table depth, 1..8.
REQ-002 Ports, each given as name, direction, width and meaning:
- bist_clk, in, 1: single clock. One clock; reset is synchronous and active-high.
- bist_rst, in, 1: synchronous active-high reset.
- bist_en, in, 1: memory port owned by BIST.
- bist_run, in, 1: level start; deassertion aborts the run.
- bist_done, out, 1: run complete.
- bist_error, out, 1: unrepairable failure.
- bist_correct, out, 1: passed using at least one spare.
- bist_error_cnt, out, 4: saturating mismatch count.
- bist_repair_cnt, out, 4: spare entries used.
- func_cen, in, 1: functional port chip enable.
- func_web, in, 1: functional port write enable.
- func_addr, in, BIST_ADDR_WD: functional port address.
- func_din, in, BIST_DATA_WD: functional port write data.
- func_dout, out, BIST_DATA_WD: equals mem_dout.
- mem_cen, out, 1: memory chip enable, active-low.
- mem_web, out, 1: memory write enable, active-low.
- mem_addr, out, BIST_ADDR_WD: memory address.
- mem_din, out, BIST_DATA_WD: memory write data.
- mem_dout, in, BIST_DATA_WD: memory read data, 1-cycle latency.

Function
REQ-003 The block SHALL run March C- as six elements: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
REQ-004 The March SHALL run twice: background B0 all-zeros, then B1 = 0x55.. replicated. "0" SHALL be the background and "1" its inverse.
REQ-005 FSM states SHALL be IDLE, RUN, FLUSH and DONE:
- IDLE to RUN when bist_run=1 and bist_en=1.
- RUN issues one operation per cycle with no bubbles between operations, elements or backgrounds.
- RUN to FLUSH after the last operation is issued.
- FLUSH to DONE after one cycle.
- DONE to IDLE when bist_run=0.
- In any state, bist_run=0 returns the FSM to IDLE next cycle; the repair table and counters are retained until the next start.
REQ-006 The address counter SHALL wrap from START/END to the next element's first address without a bubble. Descending elements SHALL start at END.
REQ-007 Read data SHALL be compared in the cycle after the read is issued, against a registered expected value. A mismatch SHALL occur when mem_dout differs from the expected value in any bit.
REQ-008 On each mismatch, bist_error_cnt SHALL increment, saturating at 15.
REQ-009 Repair table behaviour on a mismatch:
- If the failing address is already in the table, no new entry is made.
- Otherwise it is written to the next free entry and bist_repair_cnt increments.
- If the table is full, bist_error SHALL be set and held.
REQ-010 A mismatch and a table hit on the same cycle for the same address SHALL consume no entry.
REQ-011 bist_done SHALL be high only in DONE. bist_correct = done & !error & (repair_cnt != 0).
REQ-012 Latency from bist_run first sampled high to bist_done high SHALL be NUM_OPS + 2 cycles, where NUM_OPS = 2 × 10 × (END − START + 1).
REQ-013 Port ownership:
- bist_en=1: the BIST drives the mem_* ports; it drives mem_cen=1 outside RUN.
- bist_en=0: func_* ports pass through to mem_*, with the address remapped.
REQ-014 Remap SHALL be combinational: a func_addr matching valid entry i SHALL become BIST_REPAIR_ADDR_START + i. Lowest index wins.
REQ-015 During RUN, BIST addresses SHALL NOT be remapped.
REQ-016 A start from IDLE SHALL clear the error counters, bist_error and the repair table.

Reset
REQ-017 On bist_rst=1 at a clock edge, all of the following SHALL reset:
- FSM to IDLE.
- bist_done, bist_error and bist_correct to 0.
- bist_error_cnt and bist_repair_cnt to 0.
- All table entries invalid.
- mem_cen and mem_web to 1.
REQ-018 Reset asserted mid-run SHALL abort within one cycle with no further memory access.

Configuration
REQ-019 With MBIST_REPAIR_EN defined, the repair table and remap SHALL be present.
REQ-020 Without MBIST_REPAIR_EN:
- No table exists.
- The first mismatch sets bist_error.
- bist_repair_cnt and bist_correct are tied to 0.
- func_addr passes through unchanged.

Structure
REQ-021 Package mbist_march_pkg SHALL hold:
- the FSM state enum;
- the March element and operation encoding typedef;
- the 6-element March table constant;
- the background constants.
REQ-022 The repair table plus remap SHALL be sub-module mbist_repair_tbl, instantiated only under MBIST_REPAIR_EN.

Verification
Bench parameters: ADDR_WD=4, START=0, END=0xB, REPAIR_START=0xC, REPAIR_CNT=2, DATA_WD=8. Memory model has 1-cycle latency.
REQ-023 Fault-free memory, bist_run=1: bist_done at cycle 242; error=0, correct=0, error_cnt=0.
REQ-024 Address 3 bit 0 stuck-at-1: done; correct=1, repair_cnt=1, error_cnt>0. Then with bist_en=0, a func access to 3 appears at mem_addr=0xC.
REQ-025 Stuck bits at addresses 2, 5 and 9: bist_error=1, repair_cnt=2, error_cnt saturates at 15 if there are at least 15 mismatches.
REQ-026 bist_run dropped at cycle 50: IDLE next cycle, mem_cen=1, done=0. Rerun after this gives the REQ-023 result.
REQ-027 bist_rst pulsed at cycle 100 of a faulty run: all outputs 0 on the next cycle. Build without MBIST_REPAIR_EN plus a single fault: bist_error=1, correct=0.
